// File: rtl/control_dac_spi.sv
// control_dac_spi
//   Sequences a serial DAC (DAC121S101-class) over a 16-bit SPI-style frame.
//   A sample tick (start) captures {2'b00, pd, dac_data}. The frame is shifted
//   out MSB-first on sdata. sync_n frames the transfer and sclk idles high.
//   After the last bit, sync_n stays high for a fixed gap. done then pulses
//   for one cycle. A start that arrives while busy is dropped and sets the
//   sticky overrun flag.
// Ports
//   clk, reset        : system clock; synchronous active-high reset
//   start             : 1-cycle request; accepted only when idle
//   dac_data[N_ADC-1:0], pd[1:0] : code and power-down bits, captured on accept
//   busy, done        : frame in flight / 1-cycle completion pulse
//   overrun           : sticky, start seen while busy
//   sclk, sync_n, sdata : serial interface to the DAC, all registered
module control_dac_spi #(
  parameter int N_ADC = 12,
  parameter int DIV   = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N_ADC-1:0] dac_data,
  input  logic [1:0]       pd,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic             sclk,
  output logic             sync_n,
  output logic             sdata
);
  localparam int F    = N_ADC + 4;
  localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW   = $clog2(F);
  localparam int GCYC = 2 * GAP * DIV;
  localparam int GW   = (GCYC > 1) ? $clog2(GCYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAPW} state_t;

  state_t          r_state;
  logic [F-1:0]    r_shift;
  logic [DW-1:0]   r_div_cnt;
  logic [BW-1:0]   r_bit_cnt;
  logic [GW-1:0]   r_gap_cnt;
  logic            r_busy, r_done, r_overrun, r_sclk, r_sync_n, r_sdata;

  logic [F-1:0]    w_frame;
  logic            w_div_wrap;

  assign w_frame    = {2'b00, pd, dac_data};
  assign w_div_wrap = (r_div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_sclk    <= 1'b1;
      r_sync_n  <= 1'b1;
      r_sdata   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A start is only dropped when a frame or gap is in progress. On the
      // done cycle the state is already IDLE, so that start is accepted.
      if (start && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_SHIFT;
            r_busy    <= 1'b1;
            r_shift   <= w_frame;
            r_sdata   <= w_frame[F-1];
            r_sync_n  <= 1'b0;
            r_sclk    <= 1'b1;
            r_div_cnt <= '0;
            r_bit_cnt <= BW'(F - 1);
          end
        end
        S_SHIFT: begin
          if (w_div_wrap) begin
            r_div_cnt <= '0;
            if (r_sclk) begin
              // Falling edge: the DAC samples here, so sdata is held.
              r_sclk <= 1'b0;
            end else begin
              r_sclk <= 1'b1;
              if (r_bit_cnt != '0) begin
                r_bit_cnt <= r_bit_cnt - 1'b1;
                r_shift   <= r_shift << 1;
                r_sdata   <= r_shift[F-2];
              end else begin
                r_sync_n  <= 1'b1;
                r_sdata   <= 1'b0;
                r_state   <= S_GAPW;
                r_gap_cnt <= '0;
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        S_GAPW: begin
          if (r_gap_cnt == GW'(GCYC - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign overrun = r_overrun;
  assign sclk    = r_sclk;
  assign sync_n  = r_sync_n;
  assign sdata   = r_sdata;
endmodule
